// File: rtl/pipe_ctrl.sv
// Pipeline sequencing and hazard controller for the 5-stage RV32IM core.
// Optional feature macro PIPE_CTRL_PERF_EN adds stall/flush performance counters.
module pipe_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_div,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  div_start,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events,
`endif
  output logic                  div_busy
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [7:0] CNT_INIT = 8'(DIV_CYCLES - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       load_use;
  logic       div_trig;

  assign load_use = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign div_trig = (state == RUN) & ex_is_div & ~mem_busy;

  // The divider keeps iterating under mem_busy, so DIV -> DONE follows cnt alone.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (div_trig) begin
          state_nxt = DIV;
          cnt_nxt   = CNT_INIT;
        end
      end
      DIV: begin
        if (cnt == 8'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      DONE: begin
        if (!mem_busy) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    div_start   = 1'b0;
    div_busy    = 1'b0;
    if (rst) begin
      if (mem_busy) begin
        div_busy = (state == DIV);
      end else if (div_trig || state == DIV) begin
        exmem_en    = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
        div_start   = div_trig;
        div_busy    = (state == DIV);
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        // DONE lets the quotient advance; branch outranks the load-use bubble.
        if (state == RUN) begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (!pc_en)     stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing and hazard controller for the 5-stage RV32IM core. It drives the enable and bubble-insert (flush) controls of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. The pipeline registers are enable-only registers with async reset; a flush means the register's d-input is muxed to NOP/zero-control while en=1. It handles load-use stalls, taken-branch flushes, data-memory wait freezes, and multi-cycle DIV/REM sequencing with an internal cycle counter.

Parameters:
DIV_CYCLES, 32, number of divider iterations (legal range 1..255)
REG_ADDR_W, 5, register-index width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
id_rs1  input  REG_ADDR_W  rs1 index of instruction in ID
id_rs2  input  REG_ADDR_W  rs2 index of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd  input  REG_ADDR_W  destination of instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_reg_write  input  1  EX instruction writes rd
ex_is_div  input  1  EX instruction is DIV/DIVU/REM/REMU
ex_branch_taken  input  1  EX resolved taken branch/jump
mem_busy  input  1  data memory not ready; freeze whole pipe
pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  register enables
ifid_flush, idex_flush, exmem_flush  output  1 each  insert bubble into that register
div_start  output  1  one-cycle pulse launching divider
div_busy  output  1  divider iterating

Behaviour:
- FSM states: RUN, DIV, DONE. Reset: state=RUN, cnt=0 (8-bit down-counter).
- While rst low, all outputs are 0 (outputs are gated by rst combinationally).
- Default outputs (RUN, no hazard): all en=1, all flush=0, div_start=0, div_busy=0.
- Priority, highest first: mem_busy > div sequencing > branch flush > load-use stall.
- mem_busy=1: all five en=0, all flush=0. The FSM state is held, except that cnt keeps decrementing in DIV because the divider runs independently.
- Div trigger: RUN & ex_is_div & !mem_busy. Outputs div_start=1, pc_en=ifid_en=idex_en=0, exmem_en=1 with exmem_flush=1, memwb_en=1. Loads cnt=DIV_CYCLES-1. Next state DIV.
- DIV: div_busy=1, same stall/bubble pattern as the trigger cycle. cnt decrements each cycle. When cnt==0, next state is DONE.
- DONE: all en=1, no flush (div result advances to EX/MEM). Next state RUN if !mem_busy, otherwise hold. ex_is_div is ignored in DONE.
- A DIV therefore occupies EX for exactly DIV_CYCLES+2 cycles when mem_busy=0 (32 -> 34).
- Branch: ex_branch_taken in RUN sets ifid_flush=1 and idex_flush=1; all en=1. This overrides a simultaneous load-use hazard.
- Load-use hazard: ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). Response: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1; exmem/memwb en=1. Exactly one bubble per hazard.
- ex_rd==0 never causes a stall.
- Async reset asserted mid-DIV returns to RUN with cnt=0 immediately; no div_start on release unless the trigger condition is present.

Optional Feature:
Macro PIPE_CTRL_PERF_EN. When defined, adds outputs stall_cycles[31:0] and flush_events[31:0], both reset to 0.
- stall_cycles increments on every cycle with pc_en=0 while rst is high.
- flush_events increments on each cycle with ifid_flush=1.
- Both wrap from 0xFFFFFFFF to 0.
When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs -> all outputs 0; first cycle after release with quiet inputs -> all en=1, flushes 0.
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1. Same stimulus with ex_rd=0 -> no stall.
- Branch and load-use together: ex_branch_taken=1 plus the hazard above -> ifid_flush=1, idex_flush=1, pc_en=1.
- DIV with DIV_CYCLES=4: ex_is_div=1 -> div_start pulses once; pc_en=0 for 5 cycles (trigger + 4 DIV); div_busy high for 4 cycles; DONE cycle has all en=1; back to RUN.
- mem_busy=1 for 3 cycles during RUN -> all en=0 and no flush for those cycles. mem_busy=1 through a DIV's counter reaching 0 -> state holds DONE until mem_busy drops.
- Reset asserted at cnt=2 in DIV -> div_busy drops immediately; after release the state is RUN. With PIPE_CTRL_PERF_EN, stall_cycles matches the total count of pc_en=0 cycles from the scenarios above.
